// File: rtl/rf_multiport_if.sv
// rtl/rf_multiport_if.sv - read, write, issue and scoreboard bus of the multiport register file
interface rf_multiport_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr0_en;
  logic [ADDR_W-1:0]        wr0_addr;
  logic [DATA_W-1:0]        wr0_data;
  logic                     wr1_en;
  logic [ADDR_W-1:0]        wr1_addr;
  logic [DATA_W-1:0]        wr1_data;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;
  logic [ADDR_W:0]          busy_count;

  // Pipeline side: drives addresses, writebacks and issues
  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           issue_en, issue_addr,
    input  rd_data, rd_busy, busy_count
  );

  // Register file side
  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           issue_en, issue_addr,
    output rd_data, rd_busy, busy_count
  );
endinterface

// File: rtl/rf_multiport.sv
// rtl/rf_multiport.sv - two-write, NUM_RD-read register file with pending-write scoreboard (optional RF_BYPASS_EN write-through)
module rf_multiport #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2
) (
  input  logic           clk,
  input  logic           reset,
  rf_multiport_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CW     = ADDR_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_nxt;
  logic [DEPTH-1:0]  set_v;
  logic [DEPTH-1:0]  clr_v;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_nxt;
  logic              inc;
  logic              dec0;
  logic              dec1;

  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_busy_c;

  // Register storage; wr1 wins a same-address collision, entry 0 is never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (bus.wr1_en && bus.wr1_addr == ADDR_W'(i)) begin
          regs[i] <= bus.wr1_data;
        end else if (bus.wr0_en && bus.wr0_addr == ADDR_W'(i)) begin
          regs[i] <= bus.wr0_data;
        end
      end
    end
  end

  // Per-entry scoreboard next state: a new issue supersedes a writeback to the same entry
  always_comb begin
    set_v = '0;
    clr_v = '0;
    for (int a = 1; a < DEPTH; a++) begin
      set_v[a] = bus.issue_en && (bus.issue_addr == ADDR_W'(a));
      clr_v[a] = (bus.wr0_en && (bus.wr0_addr == ADDR_W'(a))) ||
                 (bus.wr1_en && (bus.wr1_addr == ADDR_W'(a)));
    end
    busy_nxt = (busy_q & ~clr_v) | set_v;
  end

  // Incremental pending count: at most one set and two distinct clears per cycle
  always_comb begin
    inc  = bus.issue_en && (bus.issue_addr != '0) && !busy_q[bus.issue_addr];
    dec0 = bus.wr0_en && (bus.wr0_addr != '0) && busy_q[bus.wr0_addr] &&
           !set_v[bus.wr0_addr];
    // When both ports hit the same entry only the wr0 term counts it
    dec1 = bus.wr1_en && (bus.wr1_addr != '0) && busy_q[bus.wr1_addr] &&
           !set_v[bus.wr1_addr] &&
           !(bus.wr0_en && (bus.wr0_addr == bus.wr1_addr));
    count_nxt = count_q + CW'(inc) - CW'(dec0) - CW'(dec1);
  end

  // Scoreboard bits and pending count registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_nxt;
      count_q <= count_nxt;
    end
  end

  // Combinational read ports with optional same-cycle write-through
  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              b;
    logic              hit0;
    logic              hit1;
    rd_data_c = '0;
    rd_busy_c = '0;
    a    = '0;
    d    = '0;
    b    = 1'b0;
    hit0 = 1'b0;
    hit1 = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      a = bus.rd_addr[k*ADDR_W +: ADDR_W];
      d = (a == '0) ? '0 : regs[a];
      b = busy_q[a];
`ifdef RF_BYPASS_EN
      hit1 = !reset && (a != '0) && bus.wr1_en && (bus.wr1_addr == a);
      hit0 = !reset && (a != '0) && bus.wr0_en && (bus.wr0_addr == a);
      if (hit1) begin
        d = bus.wr1_data;
      end else if (hit0) begin
        d = bus.wr0_data;
      end
      if (hit1 || hit0) begin
        b = bus.issue_en && (bus.issue_addr == a);
      end
`endif
      rd_data_c[k*DATA_W +: DATA_W] = d;
      rd_busy_c[k] = b;
    end
  end

  assign bus.rd_data    = rd_data_c;
  assign bus.rd_busy    = rd_busy_c;
  assign bus.busy_count = count_q;

endmodule

// File: tb/tb_rf_multiport.sv
// tb/tb_rf_multiport.sv - randomized self-checking bench for rf_multiport against an array reference model
module tb_rf_multiport;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rf_multiport_if #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) ifa ();
  rf_multiport_if #(.DATA_W(16), .DEPTH(16), .NUM_RD(4)) ifb ();

  rf_multiport #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) u_dut (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  rf_multiport #(.DATA_W(16), .DEPTH(16), .NUM_RD(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_mem [32];
  bit          m_busy [32];

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Architectural effect of one clock edge: writes land (wr1 last), writes clear, issue sets last
  task automatic model_update();
    if (ifa.wr0_en && ifa.wr0_addr != 0) begin
      m_mem[ifa.wr0_addr]  = ifa.wr0_data;
      m_busy[ifa.wr0_addr] = 1'b0;
    end
    if (ifa.wr1_en && ifa.wr1_addr != 0) begin
      m_mem[ifa.wr1_addr]  = ifa.wr1_data;
      m_busy[ifa.wr1_addr] = 1'b0;
    end
    if (ifa.issue_en && ifa.issue_addr != 0) m_busy[ifa.issue_addr] = 1'b1;
  endtask

  function automatic int popcount();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
`ifdef RF_BYPASS_EN
    if (a != 0 && ifa.wr1_en && ifa.wr1_addr == a) return ifa.wr1_data;
    if (a != 0 && ifa.wr0_en && ifa.wr0_addr == a) return ifa.wr0_data;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
`ifdef RF_BYPASS_EN
    if (a != 0 && ((ifa.wr1_en && ifa.wr1_addr == a) || (ifa.wr0_en && ifa.wr0_addr == a)))
      return ifa.issue_en && ifa.issue_addr == a;
`endif
    return m_busy[a];
  endfunction

  task automatic idle_a();
    ifa.rd_addr = '0; ifa.wr0_en = 0; ifa.wr0_addr = '0; ifa.wr0_data = '0;
    ifa.wr1_en = 0; ifa.wr1_addr = '0; ifa.wr1_data = '0;
    ifa.issue_en = 0; ifa.issue_addr = '0;
  endtask

  task automatic idle_b();
    ifb.rd_addr = '0; ifb.wr0_en = 0; ifb.wr0_addr = '0; ifb.wr0_data = '0;
    ifb.wr1_en = 0; ifb.wr1_addr = '0; ifb.wr1_data = '0;
    ifb.issue_en = 0; ifb.issue_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_a(); idle_b(); model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ifa.rd_addr = {5'd7, 5'd5};
    #1;
    n_cmp++; if (ifa.rd_data !== 64'd0) $display("FAIL reset_rd_data got %h want 0", ifa.rd_data);
    if (ifa.rd_data !== 64'd0) n_err++;
    n_cmp++; if (ifa.rd_busy !== 2'b00 || ifa.busy_count !== 6'd0) begin
      n_err++; $display("FAIL reset_busy got busy=%b count=%0d want 0/0", ifa.rd_busy, ifa.busy_count);
    end
    ifa.wr0_en = 1; ifa.wr0_addr = 5'd5; ifa.wr0_data = 32'hDEADBEEF;
    ifa.issue_en = 1; ifa.issue_addr = 5'd7;
    tick();
    idle_a(); ifa.rd_addr = {5'd7, 5'd5};
    #1;
    n_cmp++; if (ifa.rd_data[31:0] !== 32'hDEADBEEF || ifa.rd_busy[1] !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_r5 got %h busy7=%b want deadbeef/1", ifa.rd_data[31:0], ifa.rd_busy[1]);
    end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (ifa.rd_data !== 64'd0 || ifa.rd_busy !== 2'b00 || ifa.busy_count !== 6'd0) begin
      n_err++; $display("FAIL async_reset got data=%h busy=%b count=%0d want 0", ifa.rd_data, ifa.rd_busy, ifa.busy_count);
    end
    model_clear();
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (ifa.rd_data !== 64'd0 || ifa.rd_busy !== 2'b00 || ifa.busy_count !== 6'd0) begin
      n_err++; $display("FAIL after_reset got data=%h busy=%b count=%0d want 0", ifa.rd_data, ifa.rd_busy, ifa.busy_count);
    end
  endtask

  task automatic test_collision();
    idle_a();
    ifa.wr0_en = 1; ifa.wr0_addr = 5'd3; ifa.wr0_data = 32'h11;
    ifa.wr1_en = 1; ifa.wr1_addr = 5'd3; ifa.wr1_data = 32'h22;
    tick();
    idle_a();
    ifa.wr0_en = 1; ifa.wr0_addr = 5'd0; ifa.wr0_data = 32'hFFFFFFFF;
    tick();
    idle_a(); ifa.rd_addr = {5'd0, 5'd3};
    #1;
    n_cmp++; if (ifa.rd_data[31:0] !== 32'h22) begin
      n_err++; $display("FAIL collision_r3 got %h want 00000022", ifa.rd_data[31:0]);
    end
    n_cmp++; if (ifa.rd_data[63:32] !== 32'h0 || ifa.rd_busy[1] !== 1'b0) begin
      n_err++; $display("FAIL r0_write got %h busy=%b want 0/0", ifa.rd_data[63:32], ifa.rd_busy[1]);
    end
  endtask

  task automatic test_scoreboard();
    idle_a(); ifa.issue_en = 1; ifa.issue_addr = 5'd7;
    tick();
    idle_a(); ifa.rd_addr = {5'd0, 5'd7};
    #1;
    n_cmp++; if (ifa.rd_busy[0] !== 1'b1 || ifa.busy_count !== 6'd1) begin
      n_err++; $display("FAIL issue_r7 got busy=%b count=%0d want 1/1", ifa.rd_busy[0], ifa.busy_count);
    end
    tick();
    ifa.wr0_en = 1; ifa.wr0_addr = 5'd7; ifa.wr0_data = 32'h55;
    tick();
    idle_a(); ifa.rd_addr = {5'd0, 5'd7};
    #1;
    n_cmp++; if (ifa.rd_busy[0] !== 1'b0 || ifa.busy_count !== 6'd0 || ifa.rd_data[31:0] !== 32'h55) begin
      n_err++; $display("FAIL wb_r7 got busy=%b count=%0d data=%h want 0/0/55", ifa.rd_busy[0], ifa.busy_count, ifa.rd_data[31:0]);
    end
    ifa.issue_en = 1; ifa.issue_addr = 5'd9;
    tick();
    ifa.issue_en = 1; ifa.issue_addr = 5'd9;
    ifa.wr1_en = 1; ifa.wr1_addr = 5'd9; ifa.wr1_data = 32'h99;
    tick();
    idle_a(); ifa.rd_addr = {5'd0, 5'd9};
    #1;
    n_cmp++; if (ifa.rd_busy[0] !== 1'b1 || ifa.busy_count !== 6'd1) begin
      n_err++; $display("FAIL set_wins_r9 got busy=%b count=%0d want 1/1", ifa.rd_busy[0], ifa.busy_count);
    end
    ifa.issue_en = 1; ifa.issue_addr = 5'd4;
    tick();
    idle_a();
    ifa.wr0_en = 1; ifa.wr0_addr = 5'd4; ifa.wr0_data = 32'h40;
    ifa.wr1_en = 1; ifa.wr1_addr = 5'd4; ifa.wr1_data = 32'h41;
    tick();
    idle_a(); ifa.rd_addr = {5'd9, 5'd4};
    #1;
    n_cmp++; if (ifa.busy_count !== 6'd1 || ifa.rd_busy !== 2'b10 || ifa.rd_data[31:0] !== 32'h41) begin
      n_err++; $display("FAIL dual_clear_r4 got count=%0d busy=%b data=%h want 1/10/41", ifa.busy_count, ifa.rd_busy, ifa.rd_data[31:0]);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    idle_a(); ifa.wr0_en = 1; ifa.wr0_addr = 5'd6; ifa.wr0_data = 32'h0BAD;
    tick();
    idle_a();
    ifa.wr1_en = 1; ifa.wr1_addr = 5'd6; ifa.wr1_data = 32'hA5A5;
    ifa.wr0_en = 1; ifa.wr0_addr = 5'd6; ifa.wr0_data = 32'h1234;
    ifa.rd_addr = {5'd0, 5'd6};
    #1;
`ifdef RF_BYPASS_EN
    want = 32'hA5A5;
`else
    want = 32'h0BAD;
`endif
    n_cmp++; if (ifa.rd_data[31:0] !== want) begin
      n_err++; $display("FAIL bypass_same_cycle got %h want %h", ifa.rd_data[31:0], want);
    end
    tick();
    idle_a(); ifa.rd_addr = {5'd0, 5'd6};
    #1;
    n_cmp++; if (ifa.rd_data[31:0] !== 32'hA5A5) begin
      n_err++; $display("FAIL bypass_next_cycle got %h want 0000a5a5", ifa.rd_data[31:0]);
    end
  endtask

  task automatic test_random();
    logic [4:0] a;
    for (int c = 0; c < 400; c++) begin
      ifa.wr0_en = 1'($urandom_range(0, 1));
      ifa.wr0_addr = 5'($urandom_range(0, 7));
      ifa.wr0_data = $urandom;
      ifa.wr1_en = 1'($urandom_range(0, 1));
      ifa.wr1_addr = 5'($urandom_range(0, 7));
      ifa.wr1_data = $urandom;
      ifa.issue_en = 1'($urandom_range(0, 1));
      ifa.issue_addr = 5'($urandom_range(0, 7));
      ifa.rd_addr = 10'($urandom_range(0, 1023)) & 10'b00111_00111;
      #1;
      for (int k = 0; k < 2; k++) begin
        a = ifa.rd_addr[k*5 +: 5];
        n_cmp++; if (ifa.rd_data[k*32 +: 32] !== exp_rd(a)) begin
          n_err++; $display("FAIL rand_rd_data cyc=%0d port=%0d addr=%0d got %h want %h", c, k, a, ifa.rd_data[k*32 +: 32], exp_rd(a));
        end
        n_cmp++; if (ifa.rd_busy[k] !== exp_busy(a)) begin
          n_err++; $display("FAIL rand_rd_busy cyc=%0d port=%0d addr=%0d got %b want %b", c, k, a, ifa.rd_busy[k], exp_busy(a));
        end
      end
      n_cmp++; if (ifa.busy_count !== 6'(popcount())) begin
        n_err++; $display("FAIL rand_busy_count cyc=%0d got %0d want %0d", c, ifa.busy_count, popcount());
      end
      tick();
    end
    idle_a();
  endtask

  task automatic test_wide();
    logic [3:0] a;
    idle_b();
    for (int i = 1; i < 16; i++) begin
      ifb.wr0_en = 1; ifb.wr0_addr = 4'(i); ifb.wr0_data = 16'(i * 16'h0101);
      tick();
    end
    idle_b();
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) ifb.rd_addr[k*4 +: 4] = 4'(((c * 4 + k) % 15) + 1);
      #1;
      for (int k = 0; k < 4; k++) begin
        a = ifb.rd_addr[k*4 +: 4];
        n_cmp++; if (ifb.rd_data[k*16 +: 16] !== 16'(a * 16'h0101)) begin
          n_err++; $display("FAIL wide_lane c=%0d lane=%0d addr=%0d got %h want %h", c, k, a, ifb.rd_data[k*16 +: 16], 16'(a * 16'h0101));
        end
      end
      @(negedge clk);
    end
    for (int i = 1; i < 16; i++) begin
      ifb.issue_en = 1; ifb.issue_addr = 4'(i);
      tick();
    end
    idle_b();
    ifb.rd_addr = {4'd15, 4'd8, 4'd1, 4'd0};
    #1;
    n_cmp++; if (ifb.busy_count !== 5'd15 || ifb.rd_busy !== 4'b1110) begin
      n_err++; $display("FAIL wide_all_busy got count=%0d busy=%b want 15/1110", ifb.busy_count, ifb.rd_busy);
    end
  endtask

  initial begin
    test_reset();
    test_collision();
    test_scoreboard();
    test_bypass();
    test_random();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
